// File: rtl/srcctl_pkg.sv
// Shared types and encodings for the Mini SRC hardwired control unit.
// Optional mul/div support is selected with the SRCCTL_MULDIV_EN macro.
package srcctl_pkg;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  // Instruction classes; unsupported opcodes decode as ClsNop with illegal set.
  typedef enum logic [3:0] {
    ClsNop, ClsAlu, ClsImm, ClsLd, ClsLdi, ClsSt, ClsBr, ClsJr, ClsHalt, ClsMulDiv
  } cls_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;

endpackage

// File: rtl/srcctl_decode.sv
// Combinational opcode decoder: instruction class, ALU code and illegal flag.
// mul/div are only legal when SRCCTL_MULDIV_EN is defined.
module srcctl_decode
  import srcctl_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 5
) (
  input  logic [OPW-1:0]  op,
  output cls_e            cls,
  output logic [ALUW-1:0] alu,
  output logic            illegal
);

  always_comb begin
    cls     = ClsNop;
    alu     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
        cls = ClsAlu;
        alu = ALUW'(op);
      end
      OP_ADDI: begin
        cls = ClsImm;
        alu = ALUW'(ALU_ADD);
      end
      OP_ANDI: begin
        cls = ClsImm;
        alu = ALUW'(ALU_AND);
      end
      OP_ORI: begin
        cls = ClsImm;
        alu = ALUW'(ALU_OR);
      end
      // Address arithmetic for memory and branch always adds.
      OP_LD: begin
        cls = ClsLd;
        alu = ALUW'(ALU_ADD);
      end
      OP_LDI: begin
        cls = ClsLdi;
        alu = ALUW'(ALU_ADD);
      end
      OP_ST: begin
        cls = ClsSt;
        alu = ALUW'(ALU_ADD);
      end
      OP_BR: begin
        cls = ClsBr;
        alu = ALUW'(ALU_ADD);
      end
      OP_JR:   cls = ClsJr;
      OP_NOP:  cls = ClsNop;
      OP_HALT: cls = ClsHalt;
`ifdef SRCCTL_MULDIV_EN
      OP_MUL, OP_DIV: begin
        cls = ClsMulDiv;
        alu = ALUW'(op);
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/srcctl_seq.sv
// Hardwired Moore sequencer for the Mini SRC DataPath (fetch/decode/execute).
// Define SRCCTL_MULDIV_EN to add the mul/div execute sequence.
module srcctl_seq
  import srcctl_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            mem_ready,
  output logic            Pout,
  output logic            Pen,
  output logic            IncPC,
  output logic            MARen,
  output logic            MDRen,
  output logic            MDROut,
  output logic            IRen,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            ConIn,
  output logic            Yen,
  output logic            Zen,
  output logic            ZLOout,
  output logic            ZHIout,
  output logic            HIen,
  output logic            LOen,
  output logic [ALUW-1:0] alu_control,
  output logic            run,
  output logic            illegal
);

  state_e          state_q, state_d;
  cls_e            cls;
  logic [ALUW-1:0] dec_alu;
  logic            dec_illegal;

  // Operand fields are consumed by the DataPath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[31-OPW:0];

  srcctl_decode #(
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_decode (
    .op      (ir[31:32-OPW]),
    .cls     (cls),
    .alu     (dec_alu),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  state_d = mem_ready ? StT2 : StT1;
      StT2:  state_d = StT3;
      StT3: begin
        case (cls)
          ClsAlu, ClsImm, ClsLd, ClsLdi, ClsSt, ClsBr: state_d = StT4;
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv: state_d = StT4;
`endif
          ClsHalt: state_d = StHalt;
          default: state_d = StT0;
        endcase
      end
      StT4: state_d = StT5;
      StT5: begin
        case (cls)
          ClsLd, ClsSt, ClsBr: state_d = StT6;
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv: state_d = StT6;
`endif
          default: state_d = StT0;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd:   state_d = mem_ready ? StT7 : StT6;
          ClsSt:   state_d = StT7;
          default: state_d = StT0;
        endcase
      end
      StT7: begin
        case (cls)
          ClsSt:   state_d = mem_ready ? StT0 : StT7;
          default: state_d = StT0;
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    {Pout, Pen, IncPC, MARen, MDRen, MDROut, IRen, Read, Write} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, ConIn}             = '0;
    {Yen, Zen, ZLOout, ZHIout, HIen, LOen}                      = '0;
    alu_control = '0;
    illegal     = 1'b0;
    run         = (state_q != StRst) && (state_q != StHalt);
    unique case (state_q)
      StT0: {Pout, MARen, IncPC} = 3'b111;
      StT1: {Read, MDRen} = 2'b11;
      StT2: {MDROut, IRen} = 2'b11;
      StT3: begin
        illegal = dec_illegal;
        case (cls)
          ClsAlu, ClsImm:      {Grb, Rout, Yen} = 3'b111;
          ClsLd, ClsLdi, ClsSt: {Grb, BAout, Yen} = 3'b111;
          ClsBr:               {Gra, Rout, ConIn} = 3'b111;
          ClsJr:               {Gra, Rout, Pen} = 3'b111;
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv:           {Gra, Rout, Yen} = 3'b111;
`endif
          default: ;
        endcase
      end
      StT4: begin
        case (cls)
          ClsAlu: begin
            {Grc, Rout, Zen} = 3'b111;
            alu_control      = dec_alu;
          end
          ClsImm, ClsLd, ClsLdi, ClsSt: begin
            {Cout, Zen} = 2'b11;
            alu_control = dec_alu;
          end
          ClsBr: {Pout, Yen} = 2'b11;
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv: begin
            {Grb, Rout, Zen} = 3'b111;
            alu_control      = dec_alu;
          end
`endif
          default: ;
        endcase
      end
      StT5: begin
        case (cls)
          ClsAlu, ClsImm, ClsLdi: {ZLOout, Gra, Rin} = 3'b111;
          ClsLd, ClsSt:           {ZLOout, MARen} = 2'b11;
          ClsBr: begin
            {Cout, Zen} = 2'b11;
            alu_control = dec_alu;
          end
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv: {ZLOout, LOen} = 2'b11;
`endif
          default: ;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd: {Read, MDRen} = 2'b11;
          ClsSt: {Gra, Rout, MDRen} = 3'b111;
          ClsBr: begin
            ZLOout = 1'b1;
            Pen    = con_ff;
          end
`ifdef SRCCTL_MULDIV_EN
          ClsMulDiv: {ZHIout, HIen} = 2'b11;
`endif
          default: ;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd:   {MDROut, Gra, Rin} = 3'b111;
          ClsSt:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
